// File: rtl/ace_core_pkg.sv
// Shared encodings for the multicycle core control path: sequencer states,
// sticky error cause codes and the default datapath width.
package ace_core_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE = 32;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXECUTE   = 4'd2,
        ST_MEM       = 4'd3,
        ST_WRITEBACK = 4'd4,
        ST_HALT      = 4'd5,
        ST_ERROR     = 4'd6
    } state_e;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of one memory transfer; expired once MEM_TIMEOUT
// stalls have accumulated. MEM_TIMEOUT of 0 never expires.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (MEM_TIMEOUT != 0) && (count_q == CW'(MEM_TIMEOUT));

    // Saturates at the limit so a late ready cannot wrap the count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (waiting && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RISC-V control sequencer: owns PC, instruction register and the
// memory request handshake; all outputs are registered.
//
// state     | meaning
// FETCH     | request instruction word at pc (first cycle after reset only arms mem_req)
// DECODE    | classify: illegal -> ERROR, system -> HALT, else EXECUTE
// EXECUTE   | latch alu result and next pc, check alignment
// MEM       | word load/store at latched address
// WRITEBACK | reg write strobe, pc update, retire
// HALT      | sticky stop after ecall/ebreak
// ERROR     | sticky fault, cause held in error_cause
module multicycle_sequencer
    import ace_core_pkg::*;
#(
    parameter int unsigned          WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
    parameter int unsigned          MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] instruction,
    input  logic                 dec_illegal,
    input  logic                 dec_is_system,
    input  logic                 dec_is_load,
    input  logic                 dec_is_store,
    input  logic                 dec_writes_rd,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] target_pc,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic [WORD_SIZE-1:0] store_data,
    output logic                 reg_we,
    output logic [WORD_SIZE-1:0] reg_wdata,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 halted,
    output logic                 error,
    output logic [1:0]           error_cause,
    output logic [3:0]           state,
    output logic [WORD_SIZE-1:0] instret
);

    state_e               state_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] next_pc_q;
    logic [WORD_SIZE-1:0] result_q;
    logic [WORD_SIZE-1:0] instr_q;
    logic [WORD_SIZE-1:0] instret_q;
    logic [WORD_SIZE-1:0] mem_addr_q;
    logic [WORD_SIZE-1:0] mem_wdata_q;
    logic [WORD_SIZE-1:0] reg_wdata_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic                 reg_we_q;
    logic                 halted_q;
    logic                 error_q;
    logic [1:0]           cause_q;

    logic [WORD_SIZE-1:0] next_pc_d;
    logic                 is_mem_op;
    logic                 timer_expired;

    assign next_pc_d = branch_taken ? target_pc : pc_q + WORD_SIZE'(4);
    assign is_mem_op = dec_is_load | dec_is_store;

    // Every request state is entered from a non-request cycle, so holding the
    // count clear while mem_req is low restarts it for each transfer.
    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!mem_req_q),
        .waiting(mem_req_q && !mem_ready),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            next_pc_q   <= RESET_PC;
            result_q    <= '0;
            instr_q     <= '0;
            instret_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        instr_q   <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DECODE;
                    end else if (timer_expired) begin
                        mem_req_q <= 1'b0;
                        error_q   <= 1'b1;
                        cause_q   <= CAUSE_TIMEOUT;
                        state_q   <= ST_ERROR;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        error_q <= 1'b1;
                        cause_q <= CAUSE_ILLEGAL;
                        state_q <= ST_ERROR;
                    end else if (dec_is_system) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    result_q  <= alu_result;
                    next_pc_q <= next_pc_d;
                    if ((next_pc_d[1:0] != 2'b00) ||
                        (is_mem_op && (alu_result[1:0] != 2'b00))) begin
                        error_q <= 1'b1;
                        cause_q <= CAUSE_MISALIGNED;
                        state_q <= ST_ERROR;
                    end else if (is_mem_op) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dec_is_store;
                        mem_addr_q  <= alu_result;
                        mem_wdata_q <= store_data;
                        state_q     <= ST_MEM;
                    end else begin
                        reg_we_q    <= dec_writes_rd & !dec_is_store;
                        reg_wdata_q <= alu_result;
                        state_q     <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (dec_is_load) begin
                            result_q <= mem_rdata;
                        end
                        reg_wdata_q <= dec_is_load ? mem_rdata : result_q;
                        reg_we_q    <= dec_writes_rd & !dec_is_store;
                        state_q     <= ST_WRITEBACK;
                    end else if (timer_expired) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        error_q   <= 1'b1;
                        cause_q   <= CAUSE_TIMEOUT;
                        state_q   <= ST_ERROR;
                    end
                end
                ST_WRITEBACK: begin
                    reg_we_q   <= 1'b0;
                    pc_q       <= next_pc_q;
                    instret_q  <= instret_q + WORD_SIZE'(1);
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= next_pc_q;
                    state_q    <= ST_FETCH;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign instruction = instr_q;
    assign reg_we      = reg_we_q;
    assign reg_wdata   = reg_wdata_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign error       = error_q;
    assign error_cause = cause_q;
    assign state       = state_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: drives memory and decoder inputs
// by hand and checks outputs on the falling edge.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, instruction;
    logic        dec_illegal, dec_is_system, dec_is_load, dec_is_store, dec_writes_rd;
    logic        branch_taken;
    logic [31:0] target_pc, alu_result, store_data;
    logic        reg_we;
    logic [31:0] reg_wdata, pc, instret;
    logic        halted, error;
    logic [1:0]  error_cause;
    logic [3:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_sequencer #(
        .WORD_SIZE  (32),
        .RESET_PC   (32'h0),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .instruction  (instruction),
        .dec_illegal  (dec_illegal),
        .dec_is_system(dec_is_system),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_writes_rd(dec_writes_rd),
        .branch_taken (branch_taken),
        .target_pc    (target_pc),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .reg_we       (reg_we),
        .reg_wdata    (reg_wdata),
        .pc           (pc),
        .halted       (halted),
        .error        (error),
        .error_cause  (error_cause),
        .state        (state),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Completes the current transfer after 'waits' stalled cycles.
    task automatic xfer(input logic [31:0] rdata, input int waits);
        mem_ready = 1'b0;
        repeat (waits) tick();
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0; mem_rdata = '0;
        dec_illegal = 1'b0; dec_is_system = 1'b0; dec_is_load = 1'b0;
        dec_is_store = 1'b0; dec_writes_rd = 1'b0; branch_taken = 1'b0;
        target_pc = '0; alu_result = '0; store_data = '0;
        tick(); tick();

        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);

        // ADDI zero-wait; ready high while mem_req low must be ignored
        rst = 1'b0; mem_ready = 1'b1;
        dec_writes_rd = 1'b1; alu_result = 32'h5;
        tick();
        check("addi_c1_req", 32'(mem_req), 32'd1);
        check("addi_c1_state", 32'(state), 32'd0);
        check("addi_c1_addr", mem_addr, 32'h0);
        check("addi_c1_we", 32'(mem_we), 32'd0);
        xfer(32'h0050_0093, 0);
        check("addi_c2_state", 32'(state), 32'd1);
        check("addi_instr", instruction, 32'h0050_0093);
        check("addi_c2_req", 32'(mem_req), 32'd0);
        tick();
        check("addi_c3_state", 32'(state), 32'd2);
        check("addi_c3_reg_we", 32'(reg_we), 32'd0);
        tick();
        check("addi_c4_state", 32'(state), 32'd4);
        check("addi_c4_reg_we", 32'(reg_we), 32'd1);
        check("addi_c4_wdata", reg_wdata, 32'h5);
        tick();
        check("addi_pc", pc, 32'h4);
        check("addi_instret", instret, 32'd1);
        check("addi_reg_we_off", 32'(reg_we), 32'd0);
        check("addi_next_addr", mem_addr, 32'h4);

        // fetch with 3 wait cycles: writeback lands in cycle 7
        alu_result = 32'hA;
        xfer(32'h00A0_0113, 3);
        check("wait3_state", 32'(state), 32'd1);
        check("wait3_instr", instruction, 32'h00A0_0113);
        check("wait3_err", 32'(error), 32'd0);
        tick(); tick();
        check("wait3_c7_state", 32'(state), 32'd4);
        check("wait3_c7_wdata", reg_wdata, 32'hA);
        tick();
        check("wait3_pc", pc, 32'h8);
        check("wait3_instret", instret, 32'd2);

        // word load
        dec_is_load = 1'b1; alu_result = 32'h100;
        xfer(32'h1000_2083, 0);
        tick(); tick();
        check("lw_state", 32'(state), 32'd3);
        check("lw_req", 32'(mem_req), 32'd1);
        check("lw_addr", mem_addr, 32'h100);
        check("lw_we", 32'(mem_we), 32'd0);
        xfer(32'hDEAD_BEEF, 1);
        check("lw_reg_we", 32'(reg_we), 32'd1);
        check("lw_wdata", reg_wdata, 32'hDEAD_BEEF);
        tick();
        check("lw_pc", pc, 32'hC);
        check("lw_instret", instret, 32'd3);

        // word store; rv2 changes mid-transfer, latched data must hold
        dec_is_load = 1'b0; dec_is_store = 1'b1;
        alu_result = 32'h200; store_data = 32'h1234_5678;
        xfer(32'h2010_A023, 0);
        tick(); tick();
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_wdata", mem_wdata, 32'h1234_5678);
        check("sw_addr", mem_addr, 32'h200);
        store_data = 32'hFFFF_FFFF; alu_result = 32'h0;
        tick();
        check("sw_wdata_hold", mem_wdata, 32'h1234_5678);
        check("sw_addr_hold", mem_addr, 32'h200);
        xfer(32'h0, 0);
        check("sw_wb_state", 32'(state), 32'd4);
        check("sw_no_reg_we", 32'(reg_we), 32'd0);
        tick();
        check("sw_pc", pc, 32'h10);
        check("sw_instret", instret, 32'd4);

        // taken branch to 0x40
        dec_is_store = 1'b0; dec_writes_rd = 1'b0;
        branch_taken = 1'b1; target_pc = 32'h40;
        xfer(32'h0200_0863, 0);
        tick(); tick();
        check("br_reg_we", 32'(reg_we), 32'd0);
        tick();
        check("br_pc", pc, 32'h40);
        check("br_addr", mem_addr, 32'h40);
        check("br_instret", instret, 32'd5);

        // misaligned branch target
        target_pc = 32'h42;
        xfer(32'h0000_0163, 0);
        tick(); tick();
        check("mis_state", 32'(state), 32'd6);
        check("mis_err", 32'(error), 32'd1);
        check("mis_cause", 32'(error_cause), 32'd2);
        check("mis_pc", pc, 32'h40);
        check("mis_reg_we", 32'(reg_we), 32'd0);
        tick();
        check("mis_sticky", 32'(error), 32'd1);
        check("mis_instret", instret, 32'd5);

        rst = 1'b1; tick();
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_err", 32'(error), 32'd0);
        check("rst2_cause", 32'(error_cause), 32'd0);
        check("rst2_instret", instret, 32'd0);
        rst = 1'b0; branch_taken = 1'b0; target_pc = '0;
        tick();

        // fetch timeout: 16 stalls, then still no ready
        mem_ready = 1'b0;
        repeat (16) tick();
        check("to_pre_state", 32'(state), 32'd0);
        check("to_pre_req", 32'(mem_req), 32'd1);
        check("to_pre_err", 32'(error), 32'd0);
        tick();
        check("to_state", 32'(state), 32'd6);
        check("to_cause", 32'(error_cause), 32'd3);
        check("to_req", 32'(mem_req), 32'd0);

        // ready on the last allowed cycle completes, then ecall halts
        rst = 1'b1; tick();
        rst = 1'b0; dec_is_system = 1'b1;
        tick();
        xfer(32'h0000_0073, 16);
        check("late_state", 32'(state), 32'd1);
        check("late_err", 32'(error), 32'd0);
        check("late_instr", instruction, 32'h0000_0073);
        tick();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_state", 32'(state), 32'd5);
        check("halt_pc", pc, 32'h0);
        check("halt_req", 32'(mem_req), 32'd0);
        repeat (3) tick();
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_sticky_st", 32'(state), 32'd5);

        // reset mid-MEM
        rst = 1'b1; tick();
        check("rst3_halt", 32'(halted), 32'd0);
        rst = 1'b0; dec_is_system = 1'b0; dec_is_load = 1'b1;
        dec_writes_rd = 1'b1; alu_result = 32'h100;
        tick();
        xfer(32'h1000_2083, 0);
        tick(); tick();
        check("mr_pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1; tick();
        check("mr_req", 32'(mem_req), 32'd0);
        check("mr_state", 32'(state), 32'd0);
        check("mr_pc", pc, 32'h0);
        check("mr_reg_we", 32'(reg_we), 32'd0);
        check("mr_addr", mem_addr, 32'h0);
        check("mr_instr", instruction, 32'h0);
        check("mr_we", 32'(mem_we), 32'd0);
        rst = 1'b0; dec_is_load = 1'b0;
        tick();
        check("mr_post_reg_we", 32'(reg_we), 32'd0);

        // illegal opcode
        dec_illegal = 1'b1;
        xfer(32'hFFFF_FFFF, 0);
        tick();
        check("ill_state", 32'(state), 32'd6);
        check("ill_cause", 32'(error_cause), 32'd1);
        check("ill_err", 32'(error), 32'd1);
        check("ill_pc", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
